// File: rtl/alu_accum_sequencer_pkg.sv
// Shared definitions for the ALU accumulator sequencer: opcodes, FSM states, width default
// and the saturating beat-count helper.
package alu_accum_sequencer_pkg;

    localparam int WIDTH_DEF = 4;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_LOAD = 3'b101;

    localparam logic [3:0] BEATS_MAX = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_RESP
    } state_e;

    function automatic logic [3:0] beats_inc(input logic [3:0] beats);
        return (beats == BEATS_MAX) ? beats : beats + 4'd1;
    endfunction

endpackage

// File: rtl/alu_accum_sequencer_if.sv
// Command and response handshake bundle between a command source (master) and the sequencer (slave).
interface alu_accum_sequencer_if
    import alu_accum_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_last;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic             rsp_zero;
    logic             rsp_err;
    logic [3:0]       rsp_beats;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_last, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err, rsp_beats
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_last, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err, rsp_beats
    );
endinterface

// File: rtl/alu_accum_sequencer_alu_step_datapath.sv
// Combinational single-beat ALU step: folds one (op, data) beat into the accumulator value.
module alu_step_datapath
    import alu_accum_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] next_acc_o,
    output logic             carry_o,
    output logic             illegal_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // The extra top bit is the ADD carry-out / SUB unsigned borrow (data > acc).
    assign sum  = {1'b0, acc_i} + {1'b0, data_i};
    assign diff = {1'b0, acc_i} - {1'b0, data_i};

    always_comb begin
        next_acc_o = acc_i;
        carry_o    = 1'b0;
        illegal_o  = 1'b0;
        case (op_i)
            OP_ADD:  begin next_acc_o = sum[WIDTH-1:0];  carry_o = sum[WIDTH];  end
            OP_SUB:  begin next_acc_o = diff[WIDTH-1:0]; carry_o = diff[WIDTH]; end
            OP_AND:  next_acc_o = acc_i & data_i;
            OP_OR:   next_acc_o = acc_i | data_i;
            OP_XOR:  next_acc_o = acc_i ^ data_i;
            OP_LOAD: next_acc_o = data_i;
            default: illegal_o  = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_accum_sequencer.sv
// Command sequencer: accumulates (op, data) beats through the ALU step and returns the
// final accumulator plus sticky status flags on the response handshake.
module alu_accum_sequencer
    import alu_accum_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    alu_accum_sequencer_if.slave bus
);
    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic             err_q;
    logic [3:0]       beats_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_carry_q;
    logic             rsp_zero_q;
    logic             rsp_err_q;
    logic [3:0]       rsp_beats_q;

    logic             beat;
    logic [WIDTH-1:0] acc_d;
    logic             alu_carry;
    logic             alu_illegal;
    logic             carry_d;
    logic             err_d;
    logic [3:0]       beats_d;

    alu_step_datapath #(.WIDTH(WIDTH)) u_alu (
        .acc_i      (acc_q),
        .data_i     (bus.cmd_data),
        .op_i       (bus.cmd_op),
        .next_acc_o (acc_d),
        .carry_o    (alu_carry),
        .illegal_o  (alu_illegal)
    );

    // cmd_ready is a pure decode of the state register, so rsp_ready never reaches it.
    assign bus.cmd_ready = (state_q != ST_RESP);
    assign beat          = bus.cmd_valid && (state_q != ST_RESP);
    assign carry_d       = carry_q | alu_carry;
    assign err_d         = err_q | alu_illegal;
    assign beats_d       = beats_inc(beats_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            carry_q      <= 1'b0;
            err_q        <= 1'b0;
            beats_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_beats_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (beat) begin
                        acc_q   <= acc_d;
                        carry_q <= carry_d;
                        err_q   <= err_d;
                        beats_q <= beats_d;
                        if (bus.cmd_last) begin
                            state_q      <= ST_RESP;
                            rsp_valid_q  <= 1'b1;
                            rsp_result_q <= acc_d;
                            rsp_carry_q  <= carry_d;
                            rsp_zero_q   <= (acc_d == '0);
                            rsp_err_q    <= err_d;
                            rsp_beats_q  <= beats_d;
                        end else begin
                            state_q <= ST_ACCUM;
                        end
                    end
                end
                ST_RESP: begin
                    // Response fields hold until taken; transaction state clears on the same edge.
                    if (bus.rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        acc_q       <= '0;
                        carry_q     <= 1'b0;
                        err_q       <= 1'b0;
                        beats_q     <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_beats  = rsp_beats_q;
endmodule

// File: tb/tb_alu_accum_sequencer.sv
// Directed bench for alu_accum_sequencer: table of transactions plus hand-written
// backpressure, reset and saturation sequences.
module tb_alu_accum_sequencer;
    import alu_accum_sequencer_pkg::*;

    localparam logic [2:0] OP_ILL6 = 3'b110;
    localparam logic [2:0] OP_ILL7 = 3'b111;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    alu_accum_sequencer_if #(.WIDTH(4)) bus ();

    alu_accum_sequencer #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         n;
        logic [2:0] op  [4];
        logic [3:0] dat [4];
        logic [3:0] r;
        logic       c;
        logic       z;
        logic       e;
        logic [3:0] b;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int n,
                                input logic [2:0] o0, input logic [3:0] d0,
                                input logic [2:0] o1, input logic [3:0] d1,
                                input logic [2:0] o2, input logic [3:0] d2,
                                input logic [2:0] o3, input logic [3:0] d3,
                                input logic [3:0] r, input logic c, input logic z,
                                input logic e, input logic [3:0] b);
        vec_t v;
        v.n = n;
        v.op[0] = o0; v.dat[0] = d0;
        v.op[1] = o1; v.dat[1] = d1;
        v.op[2] = o2; v.dat[2] = d2;
        v.op[3] = o3; v.dat[3] = d3;
        v.r = r; v.c = c; v.z = z; v.e = e; v.b = b;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive_beat(input logic [2:0] op, input logic [3:0] dat, input logic last);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = dat;
        bus.cmd_last  = last;
        @(posedge clk);
    endtask

    task automatic check_rsp(input string tag, input logic [3:0] r, input logic c,
                             input logic z, input logic e, input logic [3:0] b);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_last  = 1'b0;
        chk({tag, ".valid"},  {7'd0, bus.rsp_valid}, 8'd1);
        chk({tag, ".cready"}, {7'd0, bus.cmd_ready}, 8'd0);
        chk({tag, ".result"}, {4'd0, bus.rsp_result}, {4'd0, r});
        chk({tag, ".carry"},  {7'd0, bus.rsp_carry}, {7'd0, c});
        chk({tag, ".zero"},   {7'd0, bus.rsp_zero},  {7'd0, z});
        chk({tag, ".err"},    {7'd0, bus.rsp_err},   {7'd0, e});
        chk({tag, ".beats"},  {4'd0, bus.rsp_beats}, {4'd0, b});
    endtask

    task automatic finish_rsp(input string tag);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, ".done_valid"},  {7'd0, bus.rsp_valid}, 8'd0);
        chk({tag, ".done_cready"}, {7'd0, bus.cmd_ready}, 8'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".valid"},  {7'd0, bus.rsp_valid}, 8'd0);
        chk({tag, ".cready"}, {7'd0, bus.cmd_ready}, 8'd1);
        chk({tag, ".result"}, {4'd0, bus.rsp_result}, 8'd0);
        chk({tag, ".carry"},  {7'd0, bus.rsp_carry}, 8'd0);
        chk({tag, ".zero"},   {7'd0, bus.rsp_zero},  8'd0);
        chk({tag, ".err"},    {7'd0, bus.rsp_err},   8'd0);
        chk({tag, ".beats"},  {4'd0, bus.rsp_beats}, 8'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_ADD;
        bus.cmd_data  = 4'd0;
        bus.cmd_last  = 1'b0;
        bus.rsp_ready = 1'b0;

        // n, beats (op,data) x4, result, carry, zero, err, beats
        vecs.push_back(mk(1, OP_LOAD, 4'd9,  OP_ADD, 4'd0, OP_ADD, 4'd0, OP_ADD, 4'd0, 4'd9,  1'b0, 1'b0, 1'b0, 4'd1));
        vecs.push_back(mk(2, OP_LOAD, 4'd12, OP_ADD, 4'd7, OP_ADD, 4'd0, OP_ADD, 4'd0, 4'd3,  1'b1, 1'b0, 1'b0, 4'd2));
        vecs.push_back(mk(4, OP_LOAD, 4'd5,  OP_SUB, 4'd5, OP_SUB, 4'd1, OP_ADD, 4'd1, 4'd0,  1'b1, 1'b1, 1'b0, 4'd4));
        vecs.push_back(mk(3, OP_LOAD, 4'd6,  OP_ILL6, 4'd3, OP_XOR, 4'd15, OP_ADD, 4'd0, 4'd9, 1'b0, 1'b0, 1'b1, 4'd3));
        vecs.push_back(mk(3, OP_LOAD, 4'hA,  OP_AND, 4'h6, OP_OR, 4'h9, OP_ADD, 4'd0, 4'hB,  1'b0, 1'b0, 1'b0, 4'd3));
        vecs.push_back(mk(1, OP_ADD,  4'd0,  OP_ADD, 4'd0, OP_ADD, 4'd0, OP_ADD, 4'd0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd1));
        vecs.push_back(mk(1, OP_SUB,  4'd1,  OP_ADD, 4'd0, OP_ADD, 4'd0, OP_ADD, 4'd0, 4'hF,  1'b1, 1'b0, 1'b0, 4'd1));
        vecs.push_back(mk(2, OP_ADD,  4'd4,  OP_ILL7, 4'd2, OP_ADD, 4'd0, OP_ADD, 4'd0, 4'd4, 1'b0, 1'b0, 1'b1, 4'd2));

        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].n; k++)
                drive_beat(vecs[i].op[k], vecs[i].dat[k], (k == vecs[i].n - 1));
            check_rsp($sformatf("vec%0d", i), vecs[i].r, vecs[i].c, vecs[i].z, vecs[i].e, vecs[i].b);
            finish_rsp($sformatf("vec%0d", i));
        end

        // Backpressure: response held 5 cycles while a new beat is offered and must be ignored.
        drive_beat(OP_LOAD, 4'd3, 1'b0);
        drive_beat(OP_ADD, 4'd4, 1'b1);
        check_rsp("bp", 4'd7, 1'b0, 1'b0, 1'b0, 4'd2);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_ADD;
        bus.cmd_data  = 4'd5;
        bus.cmd_last  = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp.hold%0d.valid", j),  {7'd0, bus.rsp_valid}, 8'd1);
            chk($sformatf("bp.hold%0d.result", j), {4'd0, bus.rsp_result}, 8'd7);
            chk($sformatf("bp.hold%0d.beats", j),  {4'd0, bus.rsp_beats}, 8'd2);
            chk($sformatf("bp.hold%0d.cready", j), {7'd0, bus.cmd_ready}, 8'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("bp.release.valid",  {7'd0, bus.rsp_valid}, 8'd0);
        chk("bp.release.cready", {7'd0, bus.cmd_ready}, 8'd1);
        @(posedge clk);
        check_rsp("bp.next", 4'd5, 1'b0, 1'b0, 1'b0, 4'd1);
        finish_rsp("bp.next");

        // rsp_ready already high: response completes in its first valid cycle.
        bus.rsp_ready = 1'b1;
        drive_beat(OP_LOAD, 4'd2, 1'b1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("early.valid",  {7'd0, bus.rsp_valid}, 8'd1);
        chk("early.result", {4'd0, bus.rsp_result}, 8'd2);
        @(posedge clk);
        @(negedge clk);
        chk("early.done_valid", {7'd0, bus.rsp_valid}, 8'd0);
        bus.rsp_ready = 1'b0;

        // Reset mid-transaction discards accumulated state.
        drive_beat(OP_LOAD, 4'd4, 1'b0);
        drive_beat(OP_ADD, 4'd2, 1'b0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst.after.valid", {7'd0, bus.rsp_valid}, 8'd0);
        drive_beat(OP_ADD, 4'd3, 1'b1);
        check_rsp("midrst.next", 4'd3, 1'b0, 1'b0, 1'b0, 4'd1);
        finish_rsp("midrst.next");

        // Reset while a response is pending: it is dropped.
        drive_beat(OP_LOAD, 4'd8, 1'b1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rsprst");
        @(negedge clk);
        rst_n = 1'b1;

        // Twenty ADD 1 beats: wraps once (carry) and the beat count saturates at 15.
        for (int k = 0; k < 20; k++)
            drive_beat(OP_ADD, 4'd1, (k == 19));
        check_rsp("sat", 4'd4, 1'b1, 1'b0, 1'b0, 4'd15);
        finish_rsp("sat");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_accum_sequencer.md
# alu_accum_sequencer

Sequential command front-end that drives the team's 4-bit ALU operation set. Accepts a stream of (opcode, operand) beats over a valid/ready handshake, folds each beat into an internal accumulator through a combinational ALU datapath, and, on the last beat of a transaction, presents the result with status flags over a second valid/ready handshake. It sits between a command source (test sequencer or microcontroller bus adapter) and any result consumer.

## Interface
- WIDTH, 4: operand, accumulator and result width.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command beat present.
- cmd_ready  output  1  sequencer can accept a beat.
- cmd_op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LOAD, 110/111 illegal.
- cmd_data  input  WIDTH  operand B for this beat.
- cmd_last  input  1  beat closes the transaction.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_result  output  WIDTH  final accumulator value.
- rsp_carry  output  1  sticky: any ADD carry-out or SUB borrow in transaction.
- rsp_zero  output  1  rsp_result == 0.
- rsp_err  output  1  sticky: at least one illegal opcode in transaction.
- rsp_beats  output  4  beats accepted in transaction, saturating at 15.

## Operation
- States: IDLE, ACCUM, RESP.
- cmd_ready = 1 in IDLE and ACCUM, 0 in RESP. Beat accepted when cmd_valid && cmd_ready.
- Accumulator (acc) is 0 at start of every transaction; carry/err flags and beat count are 0.
- Per accepted beat: ADD acc = acc + data; SUB acc = acc - data; AND/OR/XOR bitwise; LOAD acc = data. All arithmetic modulo 2^WIDTH.
- Carry: ADD sets on carry-out of WIDTH+1 bit sum; SUB sets when data > acc (unsigned borrow). Flags only ever set within a transaction.
- Illegal opcode: acc unchanged, err set, beat still counted.
- IDLE: accepted beat without last -> ACCUM; with last -> RESP. ACCUM: accepted beat with last -> RESP.
- RESP: rsp_valid = 1; all rsp_* stable until rsp_valid && rsp_ready; then -> IDLE, acc/flags/count cleared in same edge.
- cmd_valid with cmd_ready low: beat ignored, source must hold it (standard handshake).
- Zero flag derived from final acc, not sticky.

## Timing
- Reset (asserted): state IDLE, acc 0, cmd_ready 1, rsp_valid 0, rsp_result 0, rsp_carry 0, rsp_zero 0, rsp_err 0, rsp_beats 0. Reset mid-transaction or mid-response discards everything; no response emitted.
- Beat processing: one beat per cycle, back-to-back, no bubbles.
- Latency: rsp_valid rises the cycle after the last beat is accepted.
- Handshake completion in RESP returns to IDLE next cycle; earliest next beat accepted one cycle after rsp handshake (one-cycle turnaround, cmd_ready low during RESP).
- rsp_ready held high before rsp_valid: response completes in its first valid cycle.
- Outputs registered; cmd_ready depends only on state, no combinational path from rsp_ready.

## Structure
- Shared package: opcode constants (ADD..LOAD), state enum (IDLE, ACCUM, RESP), WIDTH default.
- One sub-module natural: alu_step_datapath, purely combinational: inputs acc, data, op; outputs next_acc, carry, illegal. Top holds FSM, registers, flags, counter.

## Test plan
- Single-beat: LOAD 9, last -> one cycle later rsp_result 9, carry 0, zero 0, err 0, beats 1.
- Add wrap: LOAD 12, ADD 7 last -> result 3, carry 1, beats 2.
- Borrow and zero: LOAD 5, SUB 5, SUB 1, ADD 1 last -> result 0, carry 1, zero 1, beats 4.
- Illegal op: LOAD 6, op 110 data 3, XOR 15 last -> result 9, err 1, beats 3.
- Backpressure: hold rsp_ready 0 for 5 cycles during RESP -> rsp_* stable, cmd_ready 0, cmd beats ignored; release -> IDLE, next transaction starts from acc 0.
- Reset mid-transaction: LOAD 4, ADD 2, assert rst_n low -> all outputs at reset values, no response; new transaction ADD 3 last -> result 3, beats 1; also 20-beat ADD 1 transaction -> result 4, beats 15.
